// File: rtl/spi_slave_cfg.sv
// SPI slave with configurable mode, bit order and word length. SCK, select and MOSI
// are oversampled in the clk domain; TX data goes through a one-entry holding buffer.
module spi_slave_cfg #(
  parameter int                DATA_W    = 8,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] FILL      = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ssel_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bitcnt;
  logic [DATA_W-1:0]   rx_sr;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   buf_data;
  logic                buf_full;

  logic [2:0]          sck_sync;
  logic [2:0]          ssel_sync;
  logic [1:0]          mosi_sync;

  logic                sck_chg;
  logic                lead_edge;
  logic                trail_edge;
  logic                sample_edge;
  logic                shift_edge;
  logic                ssel_fall;
  logic                ssel_rise;
  logic                mosi_s;
  logic                word_start;
  logic                load;
  logic                handshake;
  logic [DATA_W-1:0]   rx_next;
  logic [DATA_W-1:0]   tx_shifted;

  // Synchronizer stage: sck/ssel_n use three flops so edges can be taken from [2:1]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {3{CPOL}};
      ssel_sync <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck};
      ssel_sync <= {ssel_sync[1:0], ssel_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sck_chg     = sck_sync[2] ^ sck_sync[1];
  assign lead_edge   = sck_chg && (sck_sync[1] != CPOL);
  assign trail_edge  = sck_chg && (sck_sync[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign ssel_fall   = ssel_sync[2] && !ssel_sync[1];
  assign ssel_rise   = !ssel_sync[2] && ssel_sync[1];
  assign mosi_s      = mosi_sync[1];

  // bitcnt is back at 0 only after a completed word, so a shift edge seen there
  // marks the start of the next word for both phases.
  assign word_start = (state == ACTIVE) && !ssel_rise && shift_edge && (bitcnt == '0);
  assign load       = CPHA ? word_start : (((state == IDLE) && ssel_fall) || word_start);
  assign handshake  = tx_valid && !buf_full;

  assign rx_next    = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr[DATA_W-1:1]};
  assign tx_shifted = MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};

  // Frame control, shift registers and TX buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bitcnt      <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      // A load sees the buffer as it was before any same-cycle handshake
      if (load) begin
        tx_sr       <= buf_full ? buf_data : FILL;
        tx_underrun <= !buf_full;
      end
      if (handshake) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end else if (load) begin
        buf_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ssel_fall) begin
            state  <= ACTIVE;
            bitcnt <= '0;
          end
        end
        ACTIVE: begin
          if (ssel_rise) begin
            state  <= IDLE;
            bitcnt <= '0;
            tx_sr  <= '0;
          end else begin
            if (sample_edge) begin
              rx_sr <= rx_next;
              if (bitcnt == LAST_BIT) begin
                bitcnt   <= '0;
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end
            if (shift_edge && !load) begin
              tx_sr <= tx_shifted;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miso     = MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0];
  assign miso_oe  = (state == ACTIVE);
  assign busy     = (state == ACTIVE);
  assign tx_ready = !buf_full;

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Bench for spi_slave_cfg: five instances covering modes 0-3, LSB-first and a 16-bit word.
module tb_spi_slave_cfg;

  localparam int NI   = 5;
  localparam int HALF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NI-1:0] sck, ssel_n, mosi, miso, miso_oe, tx_valid, tx_ready;
  logic [NI-1:0] rx_valid, tx_underrun, busy;
  logic [15:0]   tx_data [NI];
  logic [15:0]   rx_data [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW    = (g == 4) ? 16 : 8;
    localparam bit PCPOL = (g == 2 || g == 3);
    localparam bit PCPHA = (g == 1 || g == 3);
    localparam bit PMSB  = (g == 0 || g == 4);
    logic [DW-1:0] txd;
    logic [DW-1:0] rxd;
    assign txd = tx_data[g][DW-1:0];
    spi_slave_cfg #(.DATA_W(DW), .CPOL(PCPOL), .CPHA(PCPHA), .MSB_FIRST(PMSB)) u_dut (
      .clk(clk), .rst_n(rst_n), .sck(sck[g]), .ssel_n(ssel_n[g]), .mosi(mosi[g]),
      .miso(miso[g]), .miso_oe(miso_oe[g]), .tx_data(txd), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .rx_data(rxd), .rx_valid(rx_valid[g]),
      .tx_underrun(tx_underrun[g]), .busy(busy[g]));
    assign rx_data[g] = 16'(rxd);
  end

  function automatic int dw(int k);     return (k == 4) ? 16 : 8; endfunction
  function automatic bit cpol(int k);   return (k == 2 || k == 3); endfunction
  function automatic bit cpha(int k);   return (k == 1 || k == 3); endfunction
  function automatic bit msbf(int k);   return (k == 0 || k == 4); endfunction
  function automatic logic [15:0] wmask(int k); return (dw(k) == 16) ? 16'hFFFF : 16'h00FF; endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitors
  int          rxv_cnt [NI] = '{default: 0};
  int          und_cnt [NI] = '{default: 0};
  logic [15:0] rx_log  [NI][8];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rx_valid[k] === 1'b1) begin
        rx_log[k][rxv_cnt[k] % 8] = rx_data[k];
        rxv_cnt[k]++;
      end
      if (tx_underrun[k] === 1'b1) und_cnt[k]++;
    end
  end

  // Reference model of the TX holding buffer
  logic [15:0] m_buf  [NI];
  bit          m_full [NI];
  int          m_und;

  function automatic logic [15:0] m_load(int k);
    if (m_full[k]) begin
      m_full[k] = 1'b0;
      return m_buf[k];
    end
    m_und++;
    return wmask(k);
  endfunction

  task automatic wclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int k, logic [15:0] val);
    int t = 0;
    while (tx_ready[k] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL push_timeout inst %0d: tx_ready stayed %b, required 1", k, tx_ready[k]);
    end
    @(negedge clk);
    tx_data[k]  = val;
    tx_valid[k] = 1'b1;
    @(negedge clk);
    tx_valid[k] = 1'b0;
  endtask

  task automatic m_push(int k, logic [15:0] val);
    push(k, val);
    m_buf[k]  = val;
    m_full[k] = 1'b1;
  endtask

  task automatic sel(int k);
    @(negedge clk);
    ssel_n[k] = 1'b0;
    wclk(HALF);
  endtask

  task automatic desel(int k);
    wclk(HALF);
    ssel_n[k] = 1'b1;
    wclk(HALF);
  endtask

  // Master side: shifts nb bits of send, returns what it captured from miso
  task automatic bits(int k, logic [15:0] send, int nb, output logic [15:0] recv);
    int b;
    recv = '0;
    for (int i = 0; i < nb; i++) begin
      b = msbf(k) ? dw(k) - 1 - i : i;
      if (!cpha(k)) begin
        mosi[k] = send[b];
        wclk(HALF);
        recv[b] = miso[k];
        sck[k]  = !cpol(k);
        wclk(HALF);
        sck[k]  = cpol(k);
      end else begin
        sck[k]  = !cpol(k);
        mosi[k] = send[b];
        wclk(HALF);
        recv[b] = miso[k];
        sck[k]  = cpol(k);
        wclk(HALF);
      end
    end
  endtask

  task automatic check_reset_outputs(string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_miso%0d", tag, k), 32'(miso[k]), 32'd0);
      chk($sformatf("%s_oe%0d", tag, k), 32'(miso_oe[k]), 32'd0);
      chk($sformatf("%s_busy%0d", tag, k), 32'(busy[k]), 32'd0);
      chk($sformatf("%s_rxv%0d", tag, k), 32'(rx_valid[k]), 32'd0);
      chk($sformatf("%s_und%0d", tag, k), 32'(tx_underrun[k]), 32'd0);
      chk($sformatf("%s_rdy%0d", tag, k), 32'(tx_ready[k]), 32'd1);
      chk($sformatf("%s_rxd%0d", tag, k), 32'(rx_data[k]), 32'd0);
    end
  endtask

  typedef struct {
    int          inst;
    logic [15:0] mosi_w;
    logic [15:0] buf_w;
    bit          do_push;
    logic [15:0] exp_miso;
    logic [15:0] exp_rx;
    int          exp_und;
  } vec_t;

  initial begin
    vec_t        vt [8];
    logic [15:0] recv, recv2, exp_tx, w;
    int          k, nw, rx0, u0;

    vt[0] = '{0, 16'h003C, 16'h00A5, 1'b1, 16'h00A5, 16'h003C, 1};
    vt[1] = '{1, 16'h0001, 16'h006B, 1'b1, 16'h006B, 16'h0001, 0};
    vt[2] = '{2, 16'h0001, 16'h006B, 1'b1, 16'h006B, 16'h0001, 1};
    vt[3] = '{3, 16'h0001, 16'h006B, 1'b1, 16'h006B, 16'h0001, 0};
    vt[4] = '{0, 16'h0000, 16'h0000, 1'b0, 16'h00FF, 16'h0000, 2};
    vt[5] = '{1, 16'h00C3, 16'h0000, 1'b0, 16'h00FF, 16'h00C3, 1};
    vt[6] = '{4, 16'hC0DE, 16'h1234, 1'b1, 16'h1234, 16'hC0DE, 1};
    vt[7] = '{2, 16'h0096, 16'h0000, 1'b0, 16'h00FF, 16'h0096, 2};

    for (int i = 0; i < NI; i++) begin
      sck[i] = cpol(i); ssel_n[i] = 1'b1; mosi[i] = 1'b0;
      tx_valid[i] = 1'b0; tx_data[i] = '0; m_full[i] = 1'b0; m_buf[i] = '0;
    end
    rst_n = 1'b0;
    wclk(3);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    wclk(4);

    // SCK activity while deselected must not register
    rx0 = rxv_cnt[0];
    for (int i = 0; i < 20; i++) begin
      mosi[0] = 1'($urandom_range(0, 1));
      sck[0]  = ~sck[0];
      wclk(4);
    end
    chk("idle_sck_rxv", 32'(rxv_cnt[0] - rx0), 32'd0);
    chk("idle_sck_busy", 32'(busy[0]), 32'd0);

    for (int i = 0; i < 8; i++) begin
      k   = vt[i].inst;
      rx0 = rxv_cnt[k];
      u0  = und_cnt[k];
      if (vt[i].do_push) begin
        push(k, vt[i].buf_w);
        chk($sformatf("v%0d_rdy_full", i), 32'(tx_ready[k]), 32'd0);
      end
      sel(k);
      chk($sformatf("v%0d_busy", i), 32'(busy[k]), 32'd1);
      chk($sformatf("v%0d_oe", i), 32'(miso_oe[k]), 32'd1);
      bits(k, vt[i].mosi_w, dw(k), recv);
      desel(k);
      chk($sformatf("v%0d_miso", i), 32'(recv), 32'(vt[i].exp_miso));
      if (!msbf(k)) chk($sformatf("v%0d_first_bit", i), 32'(recv[0]), 32'(vt[i].exp_miso[0]));
      chk($sformatf("v%0d_rx", i), 32'(rx_data[k]), 32'(vt[i].exp_rx));
      chk($sformatf("v%0d_rxv", i), 32'(rxv_cnt[k] - rx0), 32'd1);
      chk($sformatf("v%0d_und", i), 32'(und_cnt[k] - u0), 32'(vt[i].exp_und));
      chk($sformatf("v%0d_rdy", i), 32'(tx_ready[k]), 32'd1);
      chk($sformatf("v%0d_idle", i), 32'(busy[k]), 32'd0);
    end

    // No data buffered: exactly one underrun before the word completes
    u0 = und_cnt[0];
    sel(0);
    bits(0, 16'h0000, 7, recv);
    chk("und_in_word", 32'(und_cnt[0] - u0), 32'd1);
    bits(0, 16'h0000, 1, recv2);
    desel(0);

    // Two words in one frame with a refill in between
    rx0 = rxv_cnt[0];
    push(0, 16'h005E);
    sel(0);
    push(0, 16'h00C7);
    chk("b2b_rdy_full", 32'(tx_ready[0]), 32'd0);
    bits(0, 16'h0012, 8, recv);
    bits(0, 16'h0034, 8, recv2);
    desel(0);
    chk("b2b_miso1", 32'(recv), 32'h5E);
    chk("b2b_miso2", 32'(recv2), 32'hC7);
    chk("b2b_rxv", 32'(rxv_cnt[0] - rx0), 32'd2);
    chk("b2b_rx1", 32'(rx_log[0][rx0 % 8]), 32'h12);
    chk("b2b_rx2", 32'(rx_log[0][(rx0 + 1) % 8]), 32'h34);

    // Deselect after 5 bits keeps the buffered word for the next frame
    push(0, 16'h0011);
    sel(0);
    push(0, 16'h0077);
    rx0 = rxv_cnt[0];
    bits(0, 16'h00FF, 5, recv);
    desel(0);
    chk("part_rxv", 32'(rxv_cnt[0] - rx0), 32'd0);
    chk("part_retained", 32'(tx_ready[0]), 32'd0);
    sel(0);
    bits(0, 16'h005A, 8, recv);
    desel(0);
    chk("part_next_miso", 32'(recv), 32'h77);
    chk("part_next_rx", 32'(rx_data[0]), 32'h5A);
    chk("part_next_rxv", 32'(rxv_cnt[0] - rx0), 32'd1);

    // 16-bit instance: reset at bit 9, then a clean frame
    push(4, 16'hABCD);
    sel(4);
    push(4, 16'h5555);
    bits(4, 16'h1357, 9, recv);
    @(negedge clk);
    rst_n = 1'b0;
    wclk(2);
    check_reset_outputs("rst_mid");
    ssel_n[4] = 1'b1;
    sck[4]    = cpol(4);
    wclk(4);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) m_full[i] = 1'b0;
    wclk(4);
    rx0 = rxv_cnt[4];
    push(4, 16'h2468);
    sel(4);
    bits(4, 16'hBEEF, 16, recv);
    desel(4);
    chk("w16_rx", 32'(rx_data[4]), 32'hBEEF);
    chk("w16_miso", 32'(recv), 32'h2468);
    chk("w16_rxv", 32'(rxv_cnt[4] - rx0), 32'd1);

    // Randomized frames against the buffer model
    for (int f = 0; f < 30; f++) begin
      k     = $urandom_range(0, NI - 1);
      nw    = $urandom_range(1, 3);
      m_und = 0;
      rx0   = rxv_cnt[k];
      u0    = und_cnt[k];
      exp_tx = '0;
      if (!m_full[k] && $urandom_range(0, 1) == 1) m_push(k, 16'($urandom) & wmask(k));
      sel(k);
      if (!cpha(k)) exp_tx = m_load(k);
      for (int j = 0; j < nw; j++) begin
        wclk(6);
        if (!m_full[k] && $urandom_range(0, 1) == 1) m_push(k, 16'($urandom) & wmask(k));
        if (cpha(k)) exp_tx = m_load(k);
        w = 16'($urandom) & wmask(k);
        bits(k, w, dw(k), recv);
        chk($sformatf("rnd%0d_w%0d_miso", f, j), 32'(recv), 32'(exp_tx));
        chk($sformatf("rnd%0d_w%0d_rx", f, j), 32'(rx_data[k]), 32'(w));
        if (!cpha(k)) exp_tx = m_load(k);
      end
      desel(k);
      chk($sformatf("rnd%0d_rxv", f), 32'(rxv_cnt[k] - rx0), 32'(nw));
      chk($sformatf("rnd%0d_und", f), 32'(und_cnt[k] - u0), 32'(m_und));
      chk($sformatf("rnd%0d_rdy", f), 32'(tx_ready[k]), 32'(!m_full[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
